// File: rtl/reg_cmd_decoder_pkg.sv
// reg_cmd_pkg: shared types and constants for the byte-stream register
// command decoder.
//   state_t      : decoder FSM states
//   ERR_BYTE     : single-byte response for illegal commands and read timeouts
//   CMD_WR_BIT   : command byte bit that selects write (1) or read (0)
//   bytes_for()  : number of whole bytes needed to carry a data word
//   cmd_legal()  : reserved-bit and address-range check on a command byte
package reg_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_DATA,
    WRITE,
    READ_REQ,
    READ_WAIT,
    SEND
  } state_t;

  localparam logic [7:0] ERR_BYTE   = 8'hEE;
  localparam int         CMD_WR_BIT = 7;

  function automatic int bytes_for(input int width);
    return (width + 7) / 8;
  endfunction

  // Bits [6:aw] are reserved and must be zero; the address field must also
  // fall inside the register file when depth is not a power of two.
  function automatic logic cmd_legal(input logic [7:0] cmd, input int aw,
                                     input int depth);
    int field;
    int addr;
    field = int'({25'd0, cmd[6:0]});
    addr  = field & ((1 << aw) - 1);
    return ((field >> aw) == 0) && (addr < depth);
  endfunction

endpackage

// File: rtl/reg_cmd_decoder_if.sv
// reg_cmd_decoder_if: byte links and register-block bus of the command
// decoder, grouped in one bundle.
//   rx stream  : i_rx_data / i_rx_valid / o_rx_ready   (host -> decoder)
//   tx stream  : o_tx_data / o_tx_valid / i_tx_ready   (decoder -> host)
//   write bus  : o_w_en / o_w_addr / o_w_value          (decoder -> registers)
//   read bus   : o_r_en / o_r_addr, i_r_value / i_r_valid
// Signal names keep the decoder's point of view (i_ = into the decoder).
// modport slave  : the decoder itself
// modport master : the surrounding environment (host link + register block)
interface reg_cmd_decoder_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       i_rx_data;
  logic             i_rx_valid;
  logic             o_rx_ready;
  logic [7:0]       o_tx_data;
  logic             o_tx_valid;
  logic             i_tx_ready;
  logic             o_w_en;
  logic [AW-1:0]    o_w_addr;
  logic [WIDTH-1:0] o_w_value;
  logic             o_r_en;
  logic [AW-1:0]    o_r_addr;
  logic [WIDTH-1:0] i_r_value;
  logic             i_r_valid;

  modport slave (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_r_value, i_r_valid,
    output o_rx_ready, o_tx_data, o_tx_valid,
           o_w_en, o_w_addr, o_w_value, o_r_en, o_r_addr
  );

  modport master (
    output i_rx_data, i_rx_valid, i_tx_ready, i_r_value, i_r_valid,
    input  o_rx_ready, o_tx_data, o_tx_valid,
           o_w_en, o_w_addr, o_w_value, o_r_en, o_r_addr
  );

endinterface

// File: rtl/reg_cmd_decoder_serializer.sv
// reg_resp_serializer: response byte serializer for the command decoder.
// Loads up to BYTES bytes (first byte in the top byte lane) plus a byte
// count, then presents them one at a time on a valid/ready stream.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_load       : load i_data / i_count (only while idle)
//   i_data       : response bytes, first byte in bits [PW-1 -: 8]
//   i_count      : number of bytes to send (1..BYTES)
//   o_tx_data    : current byte, held until accepted
//   o_tx_valid   : o_tx_data valid
//   i_tx_ready   : sink accepts the byte
//   o_done       : high in the cycle the last byte is accepted
module reg_resp_serializer #(
  parameter int BYTES = 2,
  localparam int PW = BYTES * 8,
  localparam int CW = $clog2(BYTES + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_load,
  input  logic [PW-1:0] i_data,
  input  logic [CW-1:0] i_count,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic          o_done
);

  logic [PW-1:0] sr;
  logic [CW-1:0] left;
  logic          valid;
  logic          fire;
  logic          last;

  assign fire       = valid && i_tx_ready;
  assign last       = (left == CW'(1));
  assign o_done     = fire && last;
  assign o_tx_data  = sr[PW-1 -: 8];
  assign o_tx_valid = valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr    <= '0;
      left  <= '0;
      valid <= 1'b0;
    end else if (i_load) begin
      sr    <= i_data;
      left  <= i_count;
      valid <= (i_count != '0);
    end else if (fire) begin
      left <= left - CW'(1);
      // The last byte is left in place so o_tx_data does not change as
      // valid falls.
      if (last) begin
        valid <= 1'b0;
      end else begin
        sr <= sr << 8;
      end
    end
  end

endmodule

// File: rtl/reg_cmd_decoder.sv
// reg_cmd_decoder: parses command bytes from a host byte link into
// single-cycle register write/read strobes and returns response bytes.
// One transaction in flight at a time.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : rx/tx byte streams and register-block bus (slave view)
//   o_busy       : high whenever the FSM is not in IDLE
//   o_cmd_err    : one-cycle pulse when an 8'hEE response is queued
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a command byte
// GET_DATA  | collecting BYTES write-data bytes, MSB first
// WRITE     | o_w_en high for one cycle
// READ_REQ  | o_r_en high for one cycle
// READ_WAIT | waiting for i_r_valid, bounded by TIMEOUT cycles
// SEND      | serializer draining the response bytes
module reg_cmd_decoder
  import reg_cmd_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  reg_cmd_decoder_if.slave    bus,
  output logic                o_busy,
  output logic                o_cmd_err
);

  localparam int BYTES = bytes_for(WIDTH);
  localparam int PW    = BYTES * 8;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CW    = $clog2(BYTES + 1);

  state_t           state;
  logic [7:0]       cmd_q;
  logic [PW-1:0]    data_sr;
  logic [BW-1:0]    byte_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic             w_en;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_value;
  logic             r_en;
  logic [AW-1:0]    r_addr;
  logic             cmd_err;

  logic             rx_ready;
  logic             rx_fire;
  logic             cmd_ok;
  logic [PW-1:0]    sr_next;
  logic             ld;
  logic [PW-1:0]    ld_data;
  logic [CW-1:0]    ld_cnt;
  logic             ser_done;

  assign rx_ready = (state == IDLE) || (state == GET_DATA);
  assign rx_fire  = bus.i_rx_valid && rx_ready;
  assign cmd_ok   = cmd_legal(bus.i_rx_data, AW, DEPTH);
  assign sr_next  = (data_sr << 8) | PW'(bus.i_rx_data);

  assign bus.o_rx_ready = rx_ready;
  assign bus.o_w_en     = w_en;
  assign bus.o_w_addr   = w_addr;
  assign bus.o_w_value  = w_value;
  assign bus.o_r_en     = r_en;
  assign bus.o_r_addr   = r_addr;
  assign o_busy         = (state != IDLE);
  assign o_cmd_err      = cmd_err;

  // Serializer loads are combinational so the response is valid on the
  // cycle after the deciding event (illegal command, write strobe, read
  // data or timeout).
  always_comb begin
    ld      = 1'b0;
    ld_data = '0;
    ld_cnt  = '0;
    case (state)
      IDLE: begin
        if (rx_fire && !cmd_ok) begin
          ld      = 1'b1;
          ld_data = PW'(ERR_BYTE) << (PW - 8);
          ld_cnt  = CW'(1);
        end
      end
      WRITE: begin
        ld      = 1'b1;
        ld_data = PW'(cmd_q) << (PW - 8);
        ld_cnt  = CW'(1);
      end
      READ_WAIT: begin
        if (bus.i_r_valid) begin
          ld      = 1'b1;
          ld_data = PW'(bus.i_r_value);
          ld_cnt  = CW'(BYTES);
        end else if (tmo_cnt == '0) begin
          ld      = 1'b1;
          ld_data = PW'(ERR_BYTE) << (PW - 8);
          ld_cnt  = CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cmd_q    <= '0;
      data_sr  <= '0;
      byte_cnt <= '0;
      tmo_cnt  <= '0;
      w_en     <= 1'b0;
      w_addr   <= '0;
      w_value  <= '0;
      r_en     <= 1'b0;
      r_addr   <= '0;
      cmd_err  <= 1'b0;
    end else begin
      w_en    <= 1'b0;
      r_en    <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_fire) begin
            cmd_q <= bus.i_rx_data;
            if (!cmd_ok) begin
              // Any data bytes of an illegal write are left on the link
              // and get decoded as fresh commands.
              cmd_err <= 1'b1;
              state   <= SEND;
            end else if (bus.i_rx_data[CMD_WR_BIT]) begin
              byte_cnt <= '0;
              state    <= GET_DATA;
            end else begin
              r_en   <= 1'b1;
              r_addr <= bus.i_rx_data[AW-1:0];
              state  <= READ_REQ;
            end
          end
        end
        GET_DATA: begin
          if (rx_fire) begin
            data_sr <= sr_next;
            if (byte_cnt == BW'(BYTES - 1)) begin
              w_en    <= 1'b1;
              w_addr  <= cmd_q[AW-1:0];
              w_value <= sr_next[WIDTH-1:0];
              state   <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + BW'(1);
            end
          end
        end
        WRITE: begin
          state <= SEND;
        end
        READ_REQ: begin
          // Terminal count is reached on the TIMEOUT-th READ_WAIT cycle.
          tmo_cnt <= TW'(TIMEOUT - 1);
          state   <= READ_WAIT;
        end
        READ_WAIT: begin
          if (bus.i_r_valid) begin
            state <= SEND;
          end else if (tmo_cnt == '0) begin
            cmd_err <= 1'b1;
            state   <= SEND;
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
        end
        SEND: begin
          if (ser_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  reg_resp_serializer #(
    .BYTES (BYTES)
  ) u_ser (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (ld),
    .i_data     (ld_data),
    .i_count    (ld_cnt),
    .o_tx_data  (bus.o_tx_data),
    .o_tx_valid (bus.o_tx_valid),
    .i_tx_ready (bus.i_tx_ready),
    .o_done     (ser_done)
  );

endmodule

// File: tb/tb_reg_cmd_decoder.sv
// tb_reg_cmd_decoder: scoreboard bench for reg_cmd_decoder with a stub
// register block (address 0 reads a fixed 16'h0B00 and ignores writes).
module tb_reg_cmd_decoder;

  localparam int TMO = 15;

  logic clk;
  logic reset_n;
  logic o_busy;
  logic o_cmd_err;

  reg_cmd_decoder_if #(.WIDTH(16), .DEPTH(32)) bus ();

  reg_cmd_decoder #(
    .WIDTH   (16),
    .DEPTH   (32),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .o_busy    (o_busy),
    .o_cmd_err (o_cmd_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cyc_w_en = 0;
  int cyc_r_en = 0;
  int cyc_tx_first = 0;
  int err_seen = 0;
  int err_exp  = 0;
  bit stub_mute = 0;
  bit tx_v_prev = 0;

  logic [7:0]  exp_tx[$];
  logic [20:0] exp_wr[$];
  logic [4:0]  exp_rd[$];
  logic [15:0] mem[32];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Stub register block: one-cycle read latency, address 0 read-only.
  initial begin
    logic        rd_go, wr_go;
    logic [4:0]  rd_a, wr_a;
    logic [15:0] wr_v;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    mem[3] = 16'hA5C3;
    mem[4] = 16'h4D2E;
    bus.i_r_valid = 1'b0;
    bus.i_r_value = '0;
    forever begin
      @(negedge clk);
      rd_go = bus.o_r_en && !stub_mute;
      rd_a  = bus.o_r_addr;
      wr_go = bus.o_w_en;
      wr_a  = bus.o_w_addr;
      wr_v  = bus.o_w_value;
      @(posedge clk);
      #1;
      if (wr_go && wr_a != 5'd0) mem[wr_a] = wr_v;
      bus.i_r_valid = rd_go;
      if (rd_go) bus.i_r_value = (rd_a == 5'd0) ? 16'h0B00 : mem[rd_a];
    end
  end

  // Output monitor: pops the scoreboard on every tx handshake and strobe.
  initial begin
    logic [7:0]  et;
    logic [20:0] ew;
    logic [4:0]  er;
    forever begin
      @(negedge clk);
      if (bus.o_tx_valid && !tx_v_prev) cyc_tx_first = cyc;
      tx_v_prev = bus.o_tx_valid;
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        if (exp_tx.size() == 0) chk("tx_extra", {8'h01, bus.o_tx_data}, 0);
        else begin
          et = exp_tx.pop_front();
          chk("tx_byte", bus.o_tx_data, et);
        end
      end
      if (bus.o_w_en) begin
        cyc_w_en = cyc;
        if (exp_wr.size() == 0) chk("wr_extra", {bus.o_w_addr, bus.o_w_value}, 21'h1FFFFF);
        else begin
          ew = exp_wr.pop_front();
          chk("wr_addr_val", {bus.o_w_addr, bus.o_w_value}, ew);
        end
      end
      if (bus.o_r_en) begin
        cyc_r_en = cyc;
        if (exp_rd.size() == 0) chk("rd_extra", {1'b1, bus.o_r_addr}, 0);
        else begin
          er = exp_rd.pop_front();
          chk("rd_addr", bus.o_r_addr, er);
        end
      end
      if (o_cmd_err) err_seen++;
    end
  end

  task automatic send_byte(input logic [7:0] b, output int acc);
    int n;
    bit got;
    n   = 0;
    got = 0;
    acc = -1000;
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    while (!got && n < 300) begin
      @(negedge clk);
      if (bus.o_rx_ready) begin
        got = 1;
        acc = cyc;
      end
      n++;
    end
    if (!got) chk("rx_accept_tmo", {56'd0, b}, 64'h100);
    @(posedge clk);
    #1;
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (exp_tx.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tx_tmo"}, 64'(n < 500), 1);
    @(negedge clk);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_strb_left"}, exp_wr.size() + exp_rd.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] out_vec();
    return {bus.o_rx_ready, bus.o_tx_valid, bus.o_tx_data, bus.o_w_en,
            bus.o_w_addr, bus.o_w_value, bus.o_r_en, bus.o_r_addr,
            o_busy, o_cmd_err};
  endfunction

  initial begin
    int  acc;
    bit  ok;
    int  n;
    reset_n        = 1'b0;
    bus.i_rx_data  = '0;
    bus.i_rx_valid = 1'b0;
    bus.i_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", out_vec(), {1'b1, 39'd0});
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Write 16'h1234 to address 5, ack is the command byte.
    exp_wr.push_back({5'd5, 16'h1234});
    exp_tx.push_back(8'h85);
    send_byte(8'h85, acc);
    send_byte(8'h12, acc);
    send_byte(8'h34, acc);
    wait_done("wr5");
    chk("wr_strobe_lat", cyc_w_en - acc, 1);
    chk("wr_ack_lat", cyc_tx_first - acc, 2);

    // Read back address 5.
    exp_rd.push_back(5'd5);
    exp_tx.push_back(8'h12);
    exp_tx.push_back(8'h34);
    send_byte(8'h05, acc);
    wait_done("rd5");
    chk("rd_strobe_lat", cyc_r_en - acc, 1);
    chk("rd_resp_lat", cyc_tx_first - acc, 3);

    // Address 0: write forwarded unchanged, read returns block's value.
    exp_wr.push_back({5'd0, 16'hFFFF});
    exp_tx.push_back(8'h80);
    send_byte(8'h80, acc);
    send_byte(8'hFF, acc);
    send_byte(8'hFF, acc);
    wait_done("wr0");
    exp_rd.push_back(5'd0);
    exp_tx.push_back(8'h0B);
    exp_tx.push_back(8'h00);
    send_byte(8'h00, acc);
    wait_done("rd0");

    // Illegal write command, next byte is a read of address 3.
    exp_tx.push_back(8'hEE);
    err_exp++;
    exp_rd.push_back(5'd3);
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'hC3);
    send_byte(8'hE0, acc);
    send_byte(8'h03, acc);
    wait_done("illegal_e0");
    chk("err_cnt_e0", err_seen, err_exp);

    // Illegal write with one reserved bit; its "data" byte is a read of 4.
    exp_tx.push_back(8'hEE);
    err_exp++;
    exp_rd.push_back(5'd4);
    exp_tx.push_back(8'h4D);
    exp_tx.push_back(8'h2E);
    send_byte(8'hA0, acc);
    send_byte(8'h04, acc);
    wait_done("illegal_a0");
    chk("err_cnt_a0", err_seen, err_exp);

    // Read timeout: stub swallows the request.
    stub_mute = 1;
    exp_rd.push_back(5'd7);
    exp_tx.push_back(8'hEE);
    err_exp++;
    send_byte(8'h07, acc);
    wait_done("timeout");
    chk("timeout_lat", cyc_tx_first - cyc_r_en, TMO + 1);
    chk("err_cnt_tmo", err_seen, err_exp);
    stub_mute = 0;

    // Backpressure on a read response.
    bus.i_tx_ready = 1'b0;
    exp_rd.push_back(5'd5);
    exp_tx.push_back(8'h12);
    exp_tx.push_back(8'h34);
    send_byte(8'h05, acc);
    n = 0;
    while (!bus.o_tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", bus.o_tx_valid, 1);
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_tx_data !== 8'h12 || bus.o_tx_valid !== 1'b1 ||
          bus.o_rx_ready !== 1'b0) ok = 0;
    end
    chk("bp_hold_stable", ok, 1);
    @(posedge clk);
    #1;
    bus.i_tx_ready = 1'b1;
    wait_done("bp");

    // Reset after the first data byte of a write.
    send_byte(8'h87, acc);
    send_byte(8'hAB, acc);
    reset_n = 1'b0;
    #1;
    chk("midreset_outputs", out_vec(), {1'b1, 39'd0});
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    exp_wr.push_back({5'd7, 16'h5566});
    exp_tx.push_back(8'h87);
    send_byte(8'h87, acc);
    send_byte(8'h55, acc);
    send_byte(8'h66, acc);
    wait_done("wr7_after_reset");
    exp_rd.push_back(5'd7);
    exp_tx.push_back(8'h55);
    exp_tx.push_back(8'h66);
    send_byte(8'h07, acc);
    wait_done("rd7_after_reset");

    chk("err_cnt_final", err_seen, err_exp);
    chk("queues_empty", exp_tx.size() + exp_wr.size() + exp_rd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
